bitstream_config_sequencer: RTL

Synthesizable sequencer that replays a stored configuration bitstream onto the CGRA config bus, then runs the flush/stall-release bring-up and monitors completion with a 64-bit cycle counter and timeout. Successor to the behavioural bring-up sequence in the sparse testbenches: parametrised in bus width, bitstream depth, flush length and number of done channels, and adds timeout, restart and optional readback verification. Sits between the host/test harness and the top-level array's `config_*`, `stall`, `flush` and `done` pins.

---
 rtl/bitstream_config_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/bitstream_config_sequencer.sv
// bitstream_config_sequencer: replays a stored config bitstream, runs flush/stall-release bring-up, then times the run until done or timeout.
// Optional feature: define CFG_READBACK_VERIFY_EN to read back and compare every written entry.
module bitstream_config_sequencer #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int DEPTH          = 4096,
   parameter int FLUSH_CYCLES   = 16,
   parameter int RELEASE_CYCLES = 2,
   parameter int NUM_DONE       = 1,
   parameter int TIMEOUT        = 20000,
   localparam int AW            = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     bs_wr_en,
   input  logic [AW-1:0]            bs_wr_addr,
   input  logic [ADDR_W+DATA_W-1:0] bs_wr_data,
   input  logic [AW:0]              bs_size,
   input  logic                     start,
   input  logic [NUM_DONE-1:0]      done_mask,
   input  logic [NUM_DONE-1:0]      done_in,
   output logic [ADDR_W-1:0]        config_config_addr,
   output logic [DATA_W-1:0]        config_config_data,
   output logic                     config_write,
   output logic                     config_read,
   input  logic [DATA_W-1:0]        config_rd_data,
   output logic                     stall,
   output logic                     flush,
   output logic [63:0]              cycle_count,
   output logic                     busy,
   output logic                     finished,
   output logic                     timed_out,
   output logic                     error
);
   localparam int CW = $clog2(FLUSH_CYCLES + RELEASE_CYCLES + 1);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   typedef enum logic [3:0] {
      S_IDLE, S_LOAD,
`ifdef CFG_READBACK_VERIFY_EN
      S_VERIFY,
`endif
      S_FLUSH, S_RELEASE, S_RUN, S_FINISHED, S_TIMEOUT, S_ERROR
   } state_t;
   state_t state_q, state_d;
   logic [AW:0] iss_q, iss_d, wr_q, wr_d, size_q, size_d;
   logic [NUM_DONE-1:0] mask_q, mask_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [63:0] cc_q, cc_d;
   logic rv_q, rv_d, cw_q, cw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W+DATA_W-1:0] rd_q;
   logic ld, rd_en, mismatch;
`ifdef CFG_READBACK_VERIFY_EN
   logic cr_q, chk_q;
   assign ld = (state_q == S_LOAD) || (state_q == S_VERIFY);
   assign rd_en = ld && (iss_q < size_q) && !rv_q && !cw_q;
   assign mismatch = chk_q && (config_rd_data != data_q);
   assign config_read = cr_q;
   assign error = state_q == S_ERROR;
`else
   logic unused_rd;
   assign unused_rd = ^config_rd_data;
   assign ld = state_q == S_LOAD;
   assign rd_en = ld && (iss_q < size_q);
   assign mismatch = 1'b0;
   assign config_read = 1'b0;
   assign error = 1'b0;
`endif
   assign busy = !(state_q inside {S_IDLE, S_FINISHED, S_TIMEOUT, S_ERROR});
   assign finished = state_q == S_FINISHED;
   assign timed_out = state_q == S_TIMEOUT;
   assign flush = (state_q == S_FLUSH) || (state_q == S_RELEASE);
   assign stall = !((state_q == S_RELEASE) || (state_q == S_RUN));
   assign cycle_count = cc_q;
   assign config_write = cw_q;
   assign config_config_addr = addr_q;
   assign config_config_data = data_q;
   // bitstream store: host writes only while idle, one-cycle synchronous read for replay
   always_ff @(posedge clk) begin
      if (bs_wr_en && !busy) mem[bs_wr_addr] <= bs_wr_data;
      rd_q <= mem[iss_q[AW-1:0]];
   end
   // state and pipeline registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         iss_q   <= '0;
         wr_q    <= '0;
         size_q  <= '0;
         mask_q  <= '0;
         cnt_q   <= '0;
         cc_q    <= '0;
         rv_q    <= 1'b0;
         cw_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         iss_q   <= iss_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         cc_q    <= cc_d;
         rv_q    <= rv_d;
         cw_q    <= cw_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end
`ifdef CFG_READBACK_VERIFY_EN
   // readback follows each write by one cycle, compare one cycle after that
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cr_q  <= 1'b0;
         chk_q <= 1'b0;
      end else begin
         cr_q  <= cw_q;
         chk_q <= cr_q;
      end
   end
`endif
   // next-state: replay, flush/release timing, run monitoring
   always_comb begin
      state_d = state_q;
      iss_d = iss_q + (AW+1)'(rd_en);
      wr_d = wr_q + (AW+1)'(cw_q);
      size_d = size_q;
      mask_d = mask_q;
      cnt_d = '0;
      cc_d = cc_q;
      rv_d = rd_en;
      cw_d = rv_q && !mismatch;
      addr_d = rv_q ? rd_q[ADDR_W+DATA_W-1:DATA_W] : addr_q;
      data_d = rv_q ? rd_q[DATA_W-1:0] : data_q;
      case (state_q)
         S_IDLE, S_FINISHED, S_TIMEOUT, S_ERROR:
            if (start) begin
               state_d = S_LOAD;
               iss_d = '0;
               wr_d = '0;
               cc_d = '0;
               size_d = (bs_size > DEPTH_C) ? DEPTH_C : bs_size;
               mask_d = done_mask;
            end
`ifdef CFG_READBACK_VERIFY_EN
         S_LOAD: state_d = (size_q == '0) ? S_FLUSH : (cw_q ? S_VERIFY : S_LOAD);
         S_VERIFY: state_d = mismatch ? S_ERROR : !chk_q ? S_VERIFY : (wr_q == size_q) ? S_FLUSH : S_LOAD;
`else
         S_LOAD: state_d = ((size_q == '0) || (cw_q && wr_d == size_q)) ? S_FLUSH : S_LOAD;
`endif
         S_FLUSH: begin
            cnt_d = (cnt_q == CW'(FLUSH_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
            state_d = (cnt_q == CW'(FLUSH_CYCLES - 1)) ? S_RELEASE : S_FLUSH;
         end
         S_RELEASE: begin
            cnt_d = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(RELEASE_CYCLES - 1)) ? S_RUN : S_RELEASE;
         end
         S_RUN: begin
            cc_d = cc_q + 64'd1;
            state_d = (&(done_in | ~mask_q)) ? S_FINISHED :
                      ((TIMEOUT != 0) && (cc_q == 64'(TIMEOUT) - 64'd1)) ? S_TIMEOUT : S_RUN;
         end
         default: state_d = state_q;
      endcase
   end
endmodule
